pipeline_hazard_ctrl: RTL

- Central sequencer for the 5-stage pipeline latches (IF/ID, ID/EX, EX/MEM, MEM/WB) and the PC register.
- Each cycle it generates one en/sRST pair per latch plus the PC enable, covering four cases: cache waits, load-use interlock, MEM-stage redirect flush and halt drain.
- Latch semantics: sRST overrides en; sRST=1 loads a bubble.
- The block holds a small run/halt FSM and saturating stall/flush performance counters.

---
 rtl/pipeline_hazard_ctrl.sv | 146 ++++++++++++++
 1 files changed

// File: rtl/pipeline_hazard_ctrl.sv
// pipeline_hazard_ctrl
// Central sequencer for the IF/ID, ID/EX, EX/MEM and MEM/WB latches and the PC.
// Each cycle it produces one enable/bubble pair per latch plus the PC enable.
// A stall, a flush, a halt drain or a data-cache wait can each change that pair.
// A latch srst overrides its en, and srst=1 loads a bubble.
//
// Ports:
//   CLK, nRST           clock, asynchronous active-low reset
//   ihit_i, dhit_i      instruction / data cache completion this cycle
//   exmem_*_i           EX/MEM latch state: dmem read/write, redirect, hlt
//   idex_dREN_i         ID/EX holds a load
//   idex_wsel_i         destination register of the ID/EX instruction
//   ifid_rs_i/rt_i      source registers of the IF/ID instruction
//   ifid_uses_rt_i      IF/ID instruction actually reads rt
//   pc_en_o             PC load enable
//   *_en_o, *_srst_o    per-latch enable and bubble insert
//   halt_o              sticky halted indication
//   stall_cnt_o         saturating count of RUN cycles with pc_en_o=0
//   flush_cnt_o         saturating count of redirects taken
module pipeline_hazard_ctrl #(
  parameter int CNT_W = 16,
  parameter int REG_W = 5
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             ihit_i,
  input  logic             dhit_i,
  input  logic             exmem_dREN_i,
  input  logic             exmem_dWEN_i,
  input  logic             exmem_redirect_i,
  input  logic             exmem_hlt_i,
  input  logic             idex_dREN_i,
  input  logic [REG_W-1:0] idex_wsel_i,
  input  logic [REG_W-1:0] ifid_rs_i,
  input  logic [REG_W-1:0] ifid_rt_i,
  input  logic             ifid_uses_rt_i,
  output logic             pc_en_o,
  output logic             ifid_en_o,
  output logic             idex_en_o,
  output logic             exmem_en_o,
  output logic             memwb_en_o,
  output logic             ifid_srst_o,
  output logic             idex_srst_o,
  output logic             exmem_srst_o,
  output logic             memwb_srst_o,
  output logic             halt_o,
  output logic [CNT_W-1:0] stall_cnt_o,
  output logic [CNT_W-1:0] flush_cnt_o
);

  typedef enum logic {
    RUN,
    HALTED
  } state_t;

  state_t           state_q, state_d;
  logic [CNT_W-1:0] stallCnt_q, flushCnt_q;
  logic             stallInc, flushInc;
  logic             dmemWait, loadUse;

  assign dmemWait = (exmem_dREN_i | exmem_dWEN_i) & ~dhit_i;

  // Register $0 is hardwired to zero, so a load targeting it never interlocks.
  assign loadUse = idex_dREN_i & (idex_wsel_i != '0) &
                   ((idex_wsel_i == ifid_rs_i) |
                    (ifid_uses_rt_i & (idex_wsel_i == ifid_rt_i)));

  always_comb begin
    state_d      = state_q;
    pc_en_o      = 1'b1;
    ifid_en_o    = 1'b1;
    idex_en_o    = 1'b1;
    exmem_en_o   = 1'b1;
    memwb_en_o   = 1'b1;
    ifid_srst_o  = 1'b0;
    idex_srst_o  = 1'b0;
    exmem_srst_o = 1'b0;
    memwb_srst_o = 1'b0;
    stallInc     = 1'b0;
    flushInc     = 1'b0;

    if (!nRST) begin
      // Hold the PC while in reset. The latches stay enabled so that they
      // clear cleanly.
      pc_en_o = 1'b0;
    end else if (state_q == HALTED) begin
      pc_en_o    = 1'b0;
      ifid_en_o  = 1'b0;
      idex_en_o  = 1'b0;
      exmem_en_o = 1'b0;
      memwb_en_o = 1'b0;
    end else begin
      if (dmemWait) begin
        // Freeze everything up to EX/MEM. Send a bubble into WB so that the
        // waiting access is not written back twice. Any pending redirect
        // stays asserted and is taken once dhit arrives.
        pc_en_o      = 1'b0;
        ifid_en_o    = 1'b0;
        idex_en_o    = 1'b0;
        exmem_en_o   = 1'b0;
        memwb_srst_o = 1'b1;
      end else if (exmem_hlt_i) begin
        pc_en_o     = 1'b0;
        ifid_srst_o = 1'b1;
        idex_srst_o = 1'b1;
        state_d     = HALTED;
      end else if (exmem_redirect_i) begin
        // The flush beats any load-use interlock, because the interlocked
        // instruction is on the wrong path anyway.
        ifid_srst_o  = 1'b1;
        idex_srst_o  = 1'b1;
        exmem_srst_o = 1'b1;
        flushInc     = 1'b1;
      end else if (loadUse) begin
        // Keep IF/ID even on an ihit miss. Its content is still the
        // instruction that must be re-decoded.
        pc_en_o     = 1'b0;
        ifid_en_o   = 1'b0;
        idex_srst_o = 1'b1;
      end else if (!ihit_i) begin
        pc_en_o     = 1'b0;
        ifid_srst_o = 1'b1;
      end
      stallInc = ~pc_en_o;
    end
  end

  always_ff @(posedge CLK or negedge nRST) begin
    if (!nRST) begin
      state_q    <= RUN;
      stallCnt_q <= '0;
      flushCnt_q <= '0;
    end else begin
      state_q <= state_d;
      if (stallInc && (stallCnt_q != {CNT_W{1'b1}}))
        stallCnt_q <= stallCnt_q + CNT_W'(1);
      if (flushInc && (flushCnt_q != {CNT_W{1'b1}}))
        flushCnt_q <= flushCnt_q + CNT_W'(1);
    end
  end

  assign halt_o      = (state_q == HALTED);
  assign stall_cnt_o = stallCnt_q;
  assign flush_cnt_o = flushCnt_q;

endmodule
